// File: rtl/pifo_leaf_bank.sv
// rtl/pifo_leaf_bank.sv - four-lane sorted leaf storage for a PIFO parent node.
// Optional occupancy output o_occ enabled by `define PIFO_LEAF_OCC_EN.
module pifo_leaf_bank #(
    parameter int PTW   = 16,
    parameter int MTW   = 32,
    parameter int DEPTH = 8,
    localparam int W    = MTW + PTW,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic [3:0]     i_push,
    input  logic [W-1:0]   i_push_data,
    input  logic [3:0]     i_pop,
    output logic [4*W-1:0] o_pop_data,
    output logic [3:0]     o_empty,
    output logic [3:0]     o_full,
    output logic [3:0]     o_overflow,
    output logic [3:0]     o_underflow
`ifdef PIFO_LEAF_OCC_EN
    ,
    output logic [4*CW-1:0] o_occ
`endif
);

    localparam logic [W-1:0]  IDLE   = {{MTW{1'b0}}, {PTW{1'b1}}};
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [W-1:0]     e [DEPTH];
        logic [W-1:0]     s [DEPTH];
        logic [W-1:0]     n [DEPTH];
        logic [DEPTH-1:0] keep;
        logic [CW-1:0]    cnt;
        logic [CW-1:0]    c_base;
        logic [CW-1:0]    c_next;
        logic             do_pop;
        logic             ovf;
        logic             udf;

        assign do_pop = i_pop[k] && (cnt != '0);

        always_comb begin
            c_base = do_pop ? cnt - 1'b1 : cnt;
            for (int i = 0; i < DEPTH - 1; i++)
                s[i] = do_pop ? e[i+1] : e[i];
            s[DEPTH-1] = do_pop ? IDLE : e[DEPTH-1];
            // keep is a thermometer: valid entries whose priority does not exceed the new word
            for (int i = 0; i < DEPTH; i++)
                keep[i] = (CW'(i) < c_base) && !(s[i][PTW-1:0] > i_push_data[PTW-1:0]);
            n[0] = (!i_push[k] || keep[0]) ? s[0] : i_push_data;
            for (int i = 1; i < DEPTH; i++) begin
                if (!i_push[k] || keep[i])
                    n[i] = s[i];
                else if (keep[i-1])
                    n[i] = i_push_data;
                else
                    n[i] = s[i-1];
            end
            c_next = (i_push[k] && (c_base != FULL_C)) ? c_base + 1'b1 : c_base;
        end

        always_ff @(posedge i_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                for (int i = 0; i < DEPTH; i++)
                    e[i] <= IDLE;
                cnt <= '0;
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    e[i] <= n[i];
                cnt <= c_next;
                if (i_push[k] && !i_pop[k] && (cnt == FULL_C))
                    ovf <= 1'b1;
                if (i_pop[k] && (cnt == '0))
                    udf <= 1'b1;
            end
        end

        assign o_pop_data[k*W +: W] = e[0];
        assign o_empty[k]           = (cnt == '0);
        assign o_full[k]            = (cnt == FULL_C);
        assign o_overflow[k]        = ovf;
        assign o_underflow[k]       = udf;
`ifdef PIFO_LEAF_OCC_EN
        assign o_occ[k*CW +: CW]    = cnt;
`endif
    end

endmodule

// File: tb/tb_pifo_leaf_bank.sv
// tb/tb_pifo_leaf_bank.sv - directed and randomized bench with a queue-based reference model.
module tb_pifo_leaf_bank;

    localparam int PTW   = 16;
    localparam int MTW   = 32;
    localparam int DEPTH = 8;
    localparam int W     = MTW + PTW;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [W-1:0] IDLE = {{MTW{1'b0}}, {PTW{1'b1}}};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     push = '0;
    logic [W-1:0]   push_data = '0;
    logic [3:0]     pop = '0;
    logic [4*W-1:0] pop_data;
    logic [3:0]     empty, full, overflow, underflow;
`ifdef PIFO_LEAF_OCC_EN
    logic [4*CW-1:0] occ;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mq [4][$];
    logic [3:0]   mo = '0;
    logic [3:0]   mu = '0;

    always #5 clk = ~clk;

    pifo_leaf_bank #(.PTW(PTW), .MTW(MTW), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_pop_data  (pop_data),
        .o_empty     (empty),
        .o_full      (full),
        .o_overflow  (overflow),
        .o_underflow (underflow)
`ifdef PIFO_LEAF_OCC_EN
        ,
        .o_occ       (occ)
`endif
    );

    function automatic logic [W-1:0] wd(input int meta, input int prio);
        return {MTW'(meta), PTW'(prio)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mq[k].delete();
        mo = '0;
        mu = '0;
    endtask

    task automatic model_step(input logic [3:0] pu, input logic [W-1:0] d, input logic [3:0] po);
        for (int k = 0; k < 4; k++) begin
            bit was_full;
            int idx;
            was_full = (mq[k].size() == DEPTH);
            if (po[k]) begin
                if (mq[k].size() == 0) mu[k] = 1'b1;
                else void'(mq[k].pop_front());
            end
            if (pu[k]) begin
                idx = mq[k].size();
                for (int j = 0; j < mq[k].size(); j++) begin
                    if (mq[k][j][PTW-1:0] > d[PTW-1:0]) begin
                        idx = j;
                        break;
                    end
                end
                mq[k].insert(idx, d);
                if (mq[k].size() > DEPTH) void'(mq[k].pop_back());
                if (!po[k] && was_full) mo[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] eh;
            eh = (mq[k].size() != 0) ? mq[k][0] : IDLE;
            chk($sformatf("%s head%0d", ph, k), 64'(pop_data[k*W +: W]), 64'(eh));
            chk($sformatf("%s empty%0d", ph, k), 64'(empty[k]), 64'(mq[k].size() == 0));
            chk($sformatf("%s full%0d", ph, k), 64'(full[k]), 64'(mq[k].size() == DEPTH));
            chk($sformatf("%s ovf%0d", ph, k), 64'(overflow[k]), 64'(mo[k]));
            chk($sformatf("%s udf%0d", ph, k), 64'(underflow[k]), 64'(mu[k]));
`ifdef PIFO_LEAF_OCC_EN
            chk($sformatf("%s occ%0d", ph, k), 64'(occ[k*CW +: CW]), 64'(mq[k].size()));
`endif
        end
    endtask

    task automatic step(input string ph, input logic [3:0] pu, input logic [W-1:0] d, input logic [3:0] po);
        @(negedge clk);
        push = pu;
        push_data = d;
        pop = po;
        @(posedge clk);
        model_step(pu, d, po);
        #1;
        check_all(ph);
        push = '0;
        pop = '0;
    endtask

    initial begin
        logic [3:0] pu, po;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_pd", 64'(pop_data[W-1:0]), 64'(wd(0, 16'hFFFF)));

        step("l0a", 4'b0001, wd(0, 30), 4'b0000);
        step("l0b", 4'b0001, wd(0, 10), 4'b0000);
        step("l0c", 4'b0001, wd(0, 20), 4'b0000);
        step("l0d", 4'b0001, wd(7, 10), 4'b0000);
        chk("plan_head10", 64'(pop_data[W-1:0]), 64'(wd(0, 10)));
        step("l0p1", 4'b0000, '0, 4'b0001);
        chk("plan_head10m7", 64'(pop_data[W-1:0]), 64'(wd(7, 10)));
        step("l0p2", 4'b0000, '0, 4'b0001);
        chk("plan_head20", 64'(pop_data[W-1:0]), 64'(wd(0, 20)));
        step("l0p3", 4'b0000, '0, 4'b0001);
        step("l0p4", 4'b0000, '0, 4'b0001);
        chk("plan_empty0", 64'(empty[0]), 64'd1);

        for (int p = 1; p <= 8; p++) step("l2fill", 4'b0100, wd(p, p), 4'b0000);
        step("l2ev", 4'b0100, wd(99, 5), 4'b0000);
        chk("plan_ovf2", 64'(overflow[2]), 64'd1);
        step("l2disc", 4'b0100, wd(98, 9), 4'b0000);
        chk("plan_l2cnt", 64'(mq[2].size()), 64'(DEPTH));
        chk("plan_l2tail", 64'(mq[2][DEPTH-1][PTW-1:0]), 64'd7);

        step("l1a", 4'b0010, wd(1, 4), 4'b0000);
        step("l1b", 4'b0010, wd(1, 9), 4'b0000);
        step("l1pp", 4'b0010, wd(2, 2), 4'b0010);
        chk("plan_l1head", 64'(pop_data[W +: W]), 64'(wd(2, 2)));
        chk("plan_l1ovf", 64'(overflow[1]), 64'd0);

        step("l3udf", 4'b0000, '0, 4'b1000);
        chk("plan_udf3", 64'(underflow[3]), 64'd1);

        step("l0three", 4'b0001, wd(3, 3), 4'b0000);
        step("bcast", 4'b1111, wd(6, 6), 4'b0001);
        chk("plan_bc0", 64'(pop_data[W-1:0]), 64'(wd(6, 6)));
        chk("plan_bc3", 64'(pop_data[3*W +: W]), 64'(wd(6, 6)));

        for (int i = 0; i < 600; i++) begin
            if ((i / 100) % 2 == 0) begin
                pu = 4'($urandom);
                po = 4'($urandom) & 4'($urandom);
            end else begin
                pu = 4'($urandom) & 4'($urandom);
                po = 4'($urandom);
            end
            step("rand", pu, wd(int'($urandom), int'($urandom_range(0, 15))), po);
        end

        for (int i = 0; i < 5; i++) step("prerst", 4'b1111, wd(i, 40 + i), 4'b0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step("postrst", 4'b0010, wd(5, 5), 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
